// File: rtl/i2c_monitor_decoder_if.sv
// Character-stream and status bundle between the I2C monitor and its consumer.
interface i2c_monitor_decoder_if;
    logic       o_valid;
    logic [7:0] o_data;
    logic       i_ready;
    logic       i_ovf_clr;
    logic       o_overflow;
    logic       o_bus_active;

    modport master (output o_valid, o_data, o_overflow, o_bus_active, input i_ready, i_ovf_clr);
    modport slave  (input o_valid, o_data, o_overflow, o_bus_active, output i_ready, i_ovf_clr);
endinterface

// File: rtl/i2c_monitor_decoder.sv
// Passive I2C sniffer rendering START/Sr/bytes/STOP as ASCII into a FWFT FIFO; `I2C_MON_ADDR_RW_EN adds W/R to address bytes.
// First character written 1 cycle after event detection; records that do not fit are dropped whole and flag o_overflow.
module i2c_monitor_decoder #(
    parameter int FILT_LEN   = 3,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_res,
    input  logic                  i_i2c_scl,
    input  logic                  i_i2c_sda,
    i2c_monitor_decoder_if.master mon
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam int CW   = 4;

    localparam logic [1:0] EV_NONE  = 2'd0;
    localparam logic [1:0] EV_START = 2'd1;
    localparam logic [1:0] EV_STOP  = 2'd2;
    localparam logic [1:0] EV_BYTE  = 2'd3;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    typedef struct packed {
        logic [1:0] kind;
        logic       restart;
        logic       trunc;
        logic [7:0] dat;
        logic       ack;
`ifdef I2C_MON_ADDR_RW_EN
        logic       addr;
`endif
    } evt_t;

    function automatic logic [7:0] hex_chr(input logic [3:0] v);
        hex_chr = (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h37 + {4'h0, v});
    endfunction

    // Bit 0 = SCL, bit 1 = SDA throughout the line conditioning
    logic [1:0]    sync1, sync2, filt, filt_q;
    logic [CW-1:0] fcnt [2];

    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            sync1   <= 2'b11;
            sync2   <= 2'b11;
            filt    <= 2'b11;
            filt_q  <= 2'b11;
            fcnt[0] <= '0;
            fcnt[1] <= '0;
        end else begin
            sync1  <= {i_i2c_sda, i_i2c_scl};
            sync2  <= sync1;
            filt_q <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == CW'(FILT_LEN - 1)) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + CW'(1);
                end
            end
        end
    end

    logic scl_rise, scl_fall, det_start, det_stop, byte_done;
    logic bus_active, smp_bit, smp_vld;
    logic [3:0] bit_cnt;
    logic [7:0] shreg;

    assign scl_rise  = filt[0] & ~filt_q[0];
    assign scl_fall  = ~filt[0] & filt_q[0];
    assign det_start = filt_q[1] & ~filt[1] & filt[0] & filt_q[0];
    // A STOP seen while idle (e.g. after a mid-transfer reset) is not reported
    assign det_stop  = ~filt_q[1] & filt[1] & filt[0] & filt_q[0] & bus_active;
    assign byte_done = scl_fall & smp_vld & bus_active & (bit_cnt == 4'd8);

    // Bits are sampled on SCL rise but committed on the following fall, so the
    // SCL rise that precedes a STOP or Sr is never counted as a data bit.
    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            bus_active <= 1'b0;
            smp_bit    <= 1'b0;
            smp_vld    <= 1'b0;
            bit_cnt    <= '0;
            shreg      <= '0;
        end else if (det_start) begin
            bus_active <= 1'b1;
            bit_cnt    <= '0;
            smp_vld    <= 1'b0;
        end else if (det_stop) begin
            bus_active <= 1'b0;
            bit_cnt    <= '0;
            smp_vld    <= 1'b0;
        end else if (bus_active) begin
            if (scl_rise) begin
                smp_bit <= filt[1];
                smp_vld <= 1'b1;
            end else if (scl_fall && smp_vld) begin
                smp_vld <= 1'b0;
                if (bit_cnt == 4'd8) begin
                    bit_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    shreg   <= {shreg[6:0], smp_bit};
                end
            end
        end
    end

`ifdef I2C_MON_ADDR_RW_EN
    logic addr_nxt;
    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res)          addr_nxt <= 1'b0;
        else if (det_start) addr_nxt <= 1'b1;
        else if (byte_done) addr_nxt <= 1'b0;
    end
`endif

    evt_t det, pend, ld;
    logic det_vld, pend_vld, ld_vld, pend_drop;
    logic [0:0] state;

    always_comb begin
        det = '0;
        if (det_start) begin
            det.kind    = EV_START;
            det.restart = bus_active;
            det.trunc   = (bit_cnt != 4'd0);
        end else if (det_stop) begin
            det.kind  = EV_STOP;
            det.trunc = (bit_cnt != 4'd0);
        end else if (byte_done) begin
            det.kind = EV_BYTE;
            det.dat  = shreg;
            det.ack  = smp_bit;
`ifdef I2C_MON_ADDR_RW_EN
            det.addr = addr_nxt;
`endif
        end
    end

    assign det_vld   = (det.kind != EV_NONE);
    assign ld        = pend_vld ? pend : det;
    assign ld_vld    = (state == ST_IDLE) && (pend_vld || det_vld);
    assign pend_drop = det_vld && (state == ST_EMIT) && pend_vld;

    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            pend_vld <= 1'b0;
            pend     <= '0;
        end else if (det_vld && ((state == ST_EMIT) || pend_vld)) begin
            if (!pend_drop) begin
                pend     <= det;
                pend_vld <= 1'b1;
            end
        end else if (ld_vld && pend_vld) begin
            pend_vld <= 1'b0;
        end
    end

    logic [7:0] rec [6];
    logic [2:0] rec_len;

    always_comb begin
        for (int i = 0; i < 6; i++) rec[i] = 8'h20;
        rec_len = 3'd0;
        if (ld.kind != EV_BYTE && ld.trunc) begin
            rec[0]  = "E";
            rec_len = 3'd2;
        end
        case (ld.kind)
            EV_START: begin
                rec[rec_len] = "S";
                if (ld.restart) begin
                    rec[rec_len + 3'd1] = "r";
                    rec_len = rec_len + 3'd3;
                end else begin
                    rec_len = rec_len + 3'd2;
                end
            end
            EV_STOP: begin
                rec[rec_len]        = "P";
                rec[rec_len + 3'd1] = 8'h0D;
                rec[rec_len + 3'd2] = 8'h0A;
                rec_len = rec_len + 3'd3;
            end
            EV_BYTE: begin
                rec[0] = hex_chr(ld.dat[7:4]);
                rec[1] = hex_chr(ld.dat[3:0]);
                rec[3] = ld.ack ? "N" : "A";
                rec_len = 3'd5;
`ifdef I2C_MON_ADDR_RW_EN
                if (ld.addr) begin
                    rec[2] = ld.dat[0] ? "R" : "W";
                    rec[3] = 8'h20;
                    rec[4] = ld.ack ? "N" : "A";
                    rec_len = 3'd6;
                end
`endif
            end
            default: ;
        endcase
    end

    logic [7:0]      fmt_chr [6];
    logic [2:0]      fmt_left;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CNTW-1:0] cnt, free_cnt;
    logic            fits, wr_en, rd_en, ovf;
    logic [7:0]      mem [FIFO_DEPTH];

    // Space is reserved at record start; only the formatter writes, so it cannot run out mid-record
    assign free_cnt = CNTW'(FIFO_DEPTH) - cnt;
    assign fits     = (free_cnt >= CNTW'(rec_len));
    assign wr_en    = (state == ST_EMIT);
    assign rd_en    = mon.o_valid && mon.i_ready;

    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            state    <= ST_IDLE;
            fmt_left <= '0;
            for (int i = 0; i < 6; i++) fmt_chr[i] <= 8'h00;
        end else if (state == ST_IDLE) begin
            if (ld_vld && fits) begin
                fmt_chr  <= rec;
                fmt_left <= rec_len;
                state    <= ST_EMIT;
            end
        end else begin
            for (int i = 0; i < 5; i++) fmt_chr[i] <= fmt_chr[i+1];
            fmt_left <= fmt_left - 3'd1;
            if (fmt_left == 3'd1) state <= ST_IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_ptr] <= fmt_chr[0];
    end

    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            if (wr_en && !rd_en)      cnt <= cnt + CNTW'(1);
            else if (!wr_en && rd_en) cnt <= cnt - CNTW'(1);
            if ((ld_vld && !fits) || pend_drop) ovf <= 1'b1;
            else if (mon.i_ovf_clr)             ovf <= 1'b0;
        end
    end

    assign mon.o_valid      = (cnt != '0);
    assign mon.o_data       = mon.o_valid ? mem[rd_ptr] : 8'h00;
    assign mon.o_overflow   = ovf;
    assign mon.o_bus_active = bus_active;
endmodule

// File: doc/i2c_monitor_decoder.md
I2C_MONITOR_DECODER -- requirements
Module: i2c_monitor_decoder

Interface
REQ-001 Parameter FILT_LEN, default 3: consecutive equal samples (1..15) required before the filtered SCL/SDA level changes.
REQ-002 Parameter FIFO_DEPTH, default 16: output character FIFO depth; power of two, 8..256.
REQ-003 i_clk  input  1  sole clock; all logic on its rising edge.
REQ-004 i_res  input  1  asynchronous, active-high reset.
REQ-005 i_i2c_scl  input  1  raw I2C SCL, asynchronous to i_clk.
REQ-006 i_i2c_sda  input  1  raw I2C SDA, asynchronous to i_clk.
REQ-007 i_ready  input  1  downstream accepts o_data this cycle.
REQ-008 i_ovf_clr  input  1  single-cycle clear of o_overflow.
REQ-009 o_valid  output  1  o_data holds a valid ASCII character.
REQ-010 o_data  output  8  ASCII character, FIFO head (first-word fall-through).
REQ-011 o_overflow  output  1  sticky: at least one record was dropped.
REQ-012 o_bus_active  output  1  high from START until STOP.

Function
REQ-013 Each line SHALL pass a 2-FF synchronizer, then a filter whose output takes a new level only after FILT_LEN consecutive equal samples; filter output resets to 1.
REQ-014 START = filtered SDA falling while filtered SCL high; STOP = filtered SDA rising while filtered SCL high.
REQ-015 Data bits SHALL be sampled MSB first on the filtered SCL rising edge; the 9th bit is ACK (0 = 'A', 1 = 'N').
REQ-016 The bit counter (0..8) SHALL clear on START, on STOP, and after the 9th bit.
REQ-017 Records (ASCII) are: START with bus idle -> "S "; START with bus active -> "Sr "; byte -> two uppercase hex digits, ' ', 'A'/'N', ' '; STOP -> "P", CR, LF.
REQ-018 START or STOP with bit counter != 0 SHALL first emit "E " (truncated byte) as part of the same record.
REQ-019 The formatter SHALL write one character per cycle into the FIFO; write of the first character SHALL occur 1 cycle after event detection.
REQ-020 A record SHALL be written only if FIFO free space >= record length at record start; otherwise the whole record is dropped and o_overflow is set.
REQ-021 One pending-event register; an event detected while formatter is busy and pending is full SHALL be dropped and set o_overflow. Operating constraint: i_clk >= 16x SCL frequency.
REQ-022 Output handshake: a transfer occurs when o_valid && i_ready; o_data SHALL be held stable while o_valid && !i_ready.
REQ-023 Simultaneous FIFO write and read at full/empty SHALL be legal; count unchanged when both occur.
REQ-024 i_ovf_clr clears o_overflow; a simultaneous set wins.
REQ-025 SCL activity with bus idle (before first START) SHALL produce no output.

Reset
REQ-026 While i_res is high: o_valid=0, o_data=8'h00, o_overflow=0, o_bus_active=0, FIFO empty, formatter idle, pending clear, bit counter 0, filtered/synced lines = 1.
REQ-027 Reset asserted mid-record SHALL discard partial records; after release no output appears until the next START.

Configuration
REQ-028 Macro I2C_MON_ADDR_RW_EN defined: the first byte after each START/Sr SHALL be emitted as two hex digits, then 'W' (bit0=0) or 'R' (bit0=1), ' ', 'A'/'N', ' ' (6 characters).
REQ-029 Macro undefined: the address byte SHALL be formatted as any other byte (5 characters), and no direction logic is synthesized.

Verification
REQ-030 i_ready=1, macro off: S, 0xA0+ACK, 0x55+NAK, P -> stream "S A0 A 55 N P\r\n"; macro on -> "S A0W A 55 N P\r\n".
REQ-031 S, 0xA0+ACK, Sr, 0xA1+ACK, 0x3C+NAK, P -> "S A0 A Sr A1 A 3C N P\r\n"; o_bus_active stays high until P.
REQ-032 FILT_LEN=3, 2-cycle low glitch on SCL and on SDA while idle -> no characters; o_bus_active=0.
REQ-033 S, 4 data bits, P -> "S E P\r\n"; next transaction decodes normally.
REQ-034 FIFO_DEPTH=16, i_ready=0, S + 4 bytes + P -> first 16 characters comprise only complete records ("S " + 2 bytes + partial-space record dropped), o_overflow=1; on i_ready=1, no partial record appears; i_ovf_clr pulse -> o_overflow=0.
REQ-035 i_res pulsed mid-byte -> o_valid=0 immediately, o_overflow=0; subsequent SCL toggles without START produce nothing.
